fft_frame_loader: RTL and testbench

Frame-level controller that sits directly in front of the fft block and behind it. It accepts a valid/ready stream of real samples and writes one N-point frame into the fft through its load port, then pulses start. It waits for done, and re-streams the N complex results with index and last markers before rearming for the next frame. The fft core is serviced one frame at a time; there is no overlap between load and compute.

---
 rtl/fft_frame_pkg.sv | 31 +++
 rtl/fft_frame_loader_streamer.sv | 91 +++++++++
 rtl/fft_frame_loader.sv | 166 ++++++++++++++++
 tb/tb_fft_frame_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_pkg.sv
// Shared types and helpers for the fft frame loader.
// Optional s_last framing is selected by FFT_FRAME_LOADER_SLAST_EN.
package fft_frame_pkg;

    typedef enum logic [2:0] {
        CLR,
        LOAD,
        FLUSH,
        START,
        RUN,
        UNLOAD
    } state_e;

    localparam int N_2_DEF = 5;
    localparam int N       = 2**N_2_DEF;
    localparam int SX_W    = 64;

    // Replicate bit in_w-1 of s into every higher bit.
    function automatic logic [SX_W-1:0] sext_sample(
        input logic [SX_W-1:0] s,
        input int              in_w
    );
        logic [SX_W-1:0] r;
        r = '0;
        for (int b = 0; b < SX_W; b++) begin
            r[b] = (b < in_w) ? s[b] : s[in_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_loader_streamer.sv
// Result streamer: finds D0, aligns to fft wd latency, emits N words.
// Exposes a done-drop strobe when FFT_FRAME_LOADER_SLAST_EN is defined.
module fft_result_streamer
    import fft_frame_pkg::*;
#(
    parameter int width   = 16,
    parameter int N_2     = 5,
    parameter int OUT_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm_i,
    input  logic               done_i,
    input  logic [2*width-1:0] wd_i,
`ifdef FFT_FRAME_LOADER_SLAST_EN
    output logic               drop_o,
`endif
    output logic               m_valid_o,
    output logic [2*width-1:0] m_data_o,
    output logic [N_2-1:0]     m_idx_o,
    output logic               m_last_o
);

    localparam bit LAT0 = (OUT_LAT == 0);

    logic               run_q, run_d;
    logic [N_2-1:0]     k_q, k_d;
    logic               m_valid_q, m_valid_d;
    logic [2*width-1:0] m_data_q, m_data_d;
    logic [N_2-1:0]     m_idx_q, m_idx_d;
    logic               m_last_q, m_last_d;

    logic           d0;
    logic           take;
    logic [N_2-1:0] kcur;

    assign d0   = arm_i & done_i;
    assign take = run_q | (LAT0 & d0);
    assign kcur = run_q ? k_q : '0;

    // Capture sequencing: arm on D0, take one wd word per cycle.
    always_comb begin
        run_d     = run_q;
        k_d       = k_q;
        m_valid_d = 1'b0;
        m_data_d  = m_data_q;
        m_idx_d   = m_idx_q;
        m_last_d  = 1'b0;
        if (d0 && !run_q) begin
            run_d = 1'b1;
            k_d   = '0;
        end
        if (take) begin
            m_valid_d = 1'b1;
            m_data_d  = wd_i;
            m_idx_d   = kcur;
            m_last_d  = (kcur == '1);
            run_d     = (kcur != '1);
            k_d       = kcur + 1'b1;
        end
    end

    // Streamer state and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            k_q       <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            run_q     <= run_d;
            k_q       <= k_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_idx_q   <= m_idx_d;
            m_last_q  <= m_last_d;
        end
    end

`ifdef FFT_FRAME_LOADER_SLAST_EN
    assign drop_o = run_q & ~done_i;
`endif

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_idx_o   = m_idx_q;
    assign m_last_o  = m_last_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Frame controller around the fft core: load N samples, start, unload.
// FFT_FRAME_LOADER_SLAST_EN adds s_last framing and a sticky frame_err.
module fft_frame_loader
    import fft_frame_pkg::*;
#(
    parameter int width   = 16,
    parameter int N_2     = 5,
    parameter int IN_W    = width - 5,
    parameter int OUT_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [IN_W-1:0]    s_data,
`ifdef FFT_FRAME_LOADER_SLAST_EN
    input  logic               s_last,
`endif
    output logic               fft_reset,
    output logic               fft_load,
    output logic [N_2-1:0]     fft_rd_adr,
    output logic [width-1:0]   fft_rd,
    output logic               fft_start,
    input  logic               fft_done,
    input  logic [2*width-1:0] fft_wd,
    output logic               m_valid,
    output logic [2*width-1:0] m_data,
    output logic [N_2-1:0]     m_idx,
    output logic               m_last,
    output logic               busy,
    output logic               frame_err
);

    state_e state_q, state_d;

    logic [N_2-1:0]   cnt_q, cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             fft_reset_q, fft_reset_d;
    logic             fft_load_q, fft_load_d;
    logic [N_2-1:0]   fft_rd_adr_q, fft_rd_adr_d;
    logic [width-1:0] fft_rd_q, fft_rd_d;
    logic             fft_start_q, fft_start_d;
    logic             busy_q, busy_d;

    logic accept;
    logic bad_last;

    assign accept = s_valid & s_ready_q;

`ifdef FFT_FRAME_LOADER_SLAST_EN
    logic err_q, err_d;
    logic miss_last;
    logic drop;
    assign bad_last  = accept & s_last & (cnt_q != '1);
    assign miss_last = accept & ~s_last & (cnt_q == '1);
`else
    assign bad_last = 1'b0;
`endif

    // Frame sequencing and sample counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLR: state_d = LOAD;
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (bad_last) begin
                        state_d = CLR;
                        cnt_d   = '0;
                    end else if (cnt_q == '1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:  state_d = START;
            START:  state_d = RUN;
            RUN:    if (fft_done) state_d = UNLOAD;
            UNLOAD: if (m_last) state_d = CLR;
            default: state_d = CLR;
        endcase
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        s_ready_d    = (state_d == LOAD);
        fft_reset_d  = (state_d == CLR);
        fft_start_d  = (state_d == START);
        busy_d       = (state_d != LOAD);
        fft_load_d   = accept & ~bad_last;
        fft_rd_adr_d = fft_rd_adr_q;
        fft_rd_d     = fft_rd_q;
        if (accept) begin
            fft_rd_adr_d = cnt_q;
            fft_rd_d     = width'(sext_sample(SX_W'(s_data), IN_W));
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLR;
            cnt_q        <= '0;
            s_ready_q    <= 1'b0;
            fft_reset_q  <= 1'b1;
            fft_load_q   <= 1'b0;
            fft_rd_adr_q <= '0;
            fft_rd_q     <= '0;
            fft_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_ready_q    <= s_ready_d;
            fft_reset_q  <= fft_reset_d;
            fft_load_q   <= fft_load_d;
            fft_rd_adr_q <= fft_rd_adr_d;
            fft_rd_q     <= fft_rd_d;
            fft_start_q  <= fft_start_d;
            busy_q       <= busy_d;
        end
    end

`ifdef FFT_FRAME_LOADER_SLAST_EN
    assign err_d = err_q | bad_last | miss_last | drop;

    // Sticky framing / protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    fft_result_streamer #(
        .width   (width),
        .N_2     (N_2),
        .OUT_LAT (OUT_LAT)
    ) u_streamer (
        .clk       (clk),
        .reset     (reset),
        .arm_i     (state_q == RUN),
        .done_i    (fft_done),
        .wd_i      (fft_wd),
`ifdef FFT_FRAME_LOADER_SLAST_EN
        .drop_o    (drop),
`endif
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_idx_o   (m_idx),
        .m_last_o  (m_last)
    );

    assign s_ready    = s_ready_q;
    assign fft_reset  = fft_reset_q;
    assign fft_load   = fft_load_q;
    assign fft_rd_adr = fft_rd_adr_q;
    assign fft_rd     = fft_rd_q;
    assign fft_start  = fft_start_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader with a behavioural fft core attached.
// Build with FFT_FRAME_LOADER_SLAST_EN to exercise s_last framing.
`timescale 1ns/1ps
module tb_fft_frame_loader;

    localparam int W   = 16;
    localparam int NB  = 5;
    localparam int IW  = 11;
    localparam int NP  = 32;
    localparam int LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            s_valid;
    logic            s_ready;
    logic [IW-1:0]   s_data;
`ifdef FFT_FRAME_LOADER_SLAST_EN
    logic            s_last;
`endif
    logic            fft_reset;
    logic            fft_load;
    logic [NB-1:0]   fft_rd_adr;
    logic [W-1:0]    fft_rd;
    logic            fft_start;
    logic            fft_done;
    logic [2*W-1:0]  fft_wd;
    logic            m_valid;
    logic [2*W-1:0]  m_data;
    logic [NB-1:0]   m_idx;
    logic            m_last;
    logic            busy;
    logic            frame_err;

    fft_frame_loader #(
        .width(W), .N_2(NB), .IN_W(IW), .OUT_LAT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef FFT_FRAME_LOADER_SLAST_EN
        .s_last(s_last),
`endif
        .fft_reset(fft_reset), .fft_load(fft_load),
        .fft_rd_adr(fft_rd_adr), .fft_rd(fft_rd),
        .fft_start(fft_start), .fft_done(fft_done), .fft_wd(fft_wd),
        .m_valid(m_valid), .m_data(m_data), .m_idx(m_idx),
        .m_last(m_last), .busy(busy), .frame_err(frame_err)
    );

    typedef int frame_t[NP];

    // Unscaled DFT bin, rounded to nearest, packed as {re, im}.
    function automatic logic [31:0] dft_bin(input frame_t x, input int k);
        real re, im, ang;
        int  ri, ii;
        re = 0.0;
        im = 0.0;
        for (int n = 0; n < NP; n++) begin
            ang = 2.0 * 3.14159265358979 * real'((k * n) % NP) / real'(NP);
            re  = re + real'(x[n]) * $cos(ang);
            im  = im - real'(x[n]) * $sin(ang);
        end
        ri = (re >= 0.0) ? $rtoi(re + 0.5) : -$rtoi(-re + 0.5);
        ii = (im >= 0.0) ? $rtoi(im + 0.5) : -$rtoi(-im + 0.5);
        return {ri[15:0], ii[15:0]};
    endfunction

    // Behavioural fft core: load port, start, level done, out_idx, wd one cycle later.
    frame_t        mem;
    logic [31:0]   res [NP];
    int            lat_cnt = -1;
    logic [NB-1:0] oidx;
    bit            kill_done = 1'b0;

    always @(posedge clk) begin
        if (fft_reset) begin
            fft_done <= 1'b0;
            lat_cnt  <= -1;
            oidx     <= '0;
        end else begin
            if (fft_load) mem[fft_rd_adr] <= int'($signed(fft_rd));
            if (fft_start) begin
                for (int k = 0; k < NP; k++) res[k] = dft_bin(mem, k);
                lat_cnt <= LAT;
            end else if (lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
            end else if (lat_cnt == 0) begin
                fft_done <= 1'b1;
                oidx     <= '0;
                lat_cnt  <= -1;
            end
            if (fft_done) begin
                if (oidx != '1) oidx <= oidx + 1'b1;
                if (kill_done && oidx == 10) fft_done <= 1'b0;
            end
            fft_wd <= res[oidx];
        end
    end

    // Monitor: collect load beats, result words and start pulses.
    typedef struct {
        logic [NB-1:0] adr;
        logic [W-1:0]  rd;
    } beat_t;

    beat_t         beats[$];
    logic [31:0]   ow[$];
    logic [NB-1:0] oi[$];
    bit            ol[$];
    int            starts;
    bit            start_ok;

    always @(negedge clk) begin
        if (reset) begin
            if (fft_load) beats.push_back('{fft_rd_adr, fft_rd});
            if (m_valid) begin
                ow.push_back(m_data);
                oi.push_back(m_idx);
                ol.push_back(m_last);
            end
            if (fft_start) begin
                starts++;
                start_ok = 1'b0;
                if (beats.size() == NP)
                    start_ok = (beats[NP-1].adr == '1) && busy && !fft_load;
            end
        end
    end

    int checks   = 0;
    int failures = 0;
    bit exp_err  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        ow.delete();
        oi.delete();
        ol.delete();
        starts   = 0;
        start_ok = 1'b0;
    endtask

    // Push n_send samples; s_last marks index last_at; checks load follows accept.
    task automatic load_frame(input frame_t x, input int n_send,
                              input bit gaps, input int last_at);
        int i   = 0;
        int cyc = 0;
        bit prv = 1'b0;
        bit v, rdy;
        while (i < n_send && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            chk("load_follows_accept", fft_load, prv);
            rdy = s_ready;
            v   = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_valid = v;
            s_data  = IW'(x[i]);
`ifdef FFT_FRAME_LOADER_SLAST_EN
            s_last  = (i == last_at);
`endif
            @(posedge clk);
            prv = v && rdy;
            if (prv) i++;
        end
        @(negedge clk);
        chk("load_follows_accept", fft_load, prv);
        chk("load_accepts", i, n_send);
        s_valid = 1'b0;
`ifdef FFT_FRAME_LOADER_SLAST_EN
        s_last  = 1'b0;
`endif
        if (last_at < 0) s_data = '0;
    endtask

    task automatic wait_results(input int n);
        int cyc = 0;
        while (ow.size() < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk("result_count", ow.size(), n);
    endtask

    // Full frame against the DFT reference model.
    task automatic run_frame(input frame_t x, input bit gaps, input bit data_chk);
        clear_mon();
        load_frame(x, NP, gaps, NP - 1);
        wait_results(NP);
        chk("beat_count", beats.size(), NP);
        for (int i = 0; i < NP && i < beats.size(); i++)
            chk("load_beat", {beats[i].adr, beats[i].rd}, {NB'(i), W'(x[i])});
        chk("start_pulses", starts, 1);
        chk("start_after_last_beat", start_ok, 1);
        for (int k = 0; k < NP && k < ow.size(); k++) begin
            chk("result_idx", {oi[k], ol[k]}, {NB'(k), k == NP - 1});
            if (data_chk) chk("result_data", ow[k], dft_bin(x, k));
        end
        chk("frame_err", frame_err, exp_err);
    endtask

    typedef struct {
        string         nm;
        logic [IW-1:0] d;
        logic [W-1:0]  rd;
    } se_vec_t;

    se_vec_t se_tab[5];
    frame_t  x;

    initial begin
        se_tab[0] = '{"sext_min",  11'h400, 16'hFC00};
        se_tab[1] = '{"sext_max",  11'h3FF, 16'h03FF};
        se_tab[2] = '{"sext_one",  11'h001, 16'h0001};
        se_tab[3] = '{"sext_m1",   11'h7FF, 16'hFFFF};
        se_tab[4] = '{"sext_zero", 11'h000, 16'h0000};

        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
`ifdef FFT_FRAME_LOADER_SLAST_EN
        s_last  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_fft_reset", fft_reset, 1);
        chk("rst_outputs", {s_ready, fft_load, fft_rd_adr, fft_rd, fft_start,
                            m_valid, m_data, m_idx, m_last, busy, frame_err}, 0);
        reset = 1'b1;

        // Impulse: every bin is {1, 0}.
        foreach (x[i]) x[i] = (i == 0) ? 1 : 0;
        run_frame(x, 1'b0, 1'b1);
        for (int k = 0; k < NP && k < ow.size(); k++)
            chk("impulse_bin", ow[k], 32'h0001_0000);

        // DC: energy only in bin 0.
        foreach (x[i]) x[i] = 4;
        run_frame(x, 1'b0, 1'b1);
        for (int k = 0; k < NP && k < ow.size(); k++) begin
            chk_near("dc_re", int'($signed(ow[k][31:16])), (k == 0) ? 128 : 0, 1);
            chk_near("dc_im", int'($signed(ow[k][15:0])), 0, 1);
        end

        // Sign extension table on the leading samples.
        foreach (x[i]) x[i] = 0;
        for (int i = 0; i < 5; i++) x[i] = int'($signed(se_tab[i].d));
        run_frame(x, 1'b1, 1'b1);
        for (int i = 0; i < 5 && i < beats.size(); i++)
            chk(se_tab[i].nm, beats[i].rd, se_tab[i].rd);

        // Random frames with random valid gaps.
        for (int f = 0; f < 3; f++) begin
            foreach (x[i]) x[i] = int'($urandom_range(0, 1000)) - 500;
            run_frame(x, 1'b1, 1'b1);
        end

        // fft_done drops mid-unload: all words still emitted.
        kill_done = 1'b1;
`ifdef FFT_FRAME_LOADER_SLAST_EN
        exp_err = 1'b1;
`endif
        foreach (x[i]) x[i] = int'($urandom_range(0, 200)) - 100;
        run_frame(x, 1'b0, 1'b0);
        kill_done = 1'b0;

        // Reset in the middle of LOAD after 17 accepts.
        clear_mon();
        foreach (x[i]) x[i] = int'($urandom_range(0, 200)) - 100;
        load_frame(x, 17, 1'b0, NP - 1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_fft_reset", fft_reset, 1);
        chk("midrst_outputs", {s_ready, fft_load, fft_rd_adr, fft_rd, fft_start,
                               m_valid, m_data, m_idx, m_last, busy, frame_err}, 0);
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (x[i]) x[i] = int'($urandom_range(0, 1000)) - 500;
        run_frame(x, 1'b1, 1'b1);

`ifdef FFT_FRAME_LOADER_SLAST_EN
        // Early s_last at cnt=9 aborts the frame.
        clear_mon();
        foreach (x[i]) x[i] = int'($urandom_range(0, 200)) - 100;
        load_frame(x, 10, 1'b0, 9);
        exp_err = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_no_results", ow.size(), 0);
        chk("abort_no_start", starts, 0);
        chk("abort_err", frame_err, 1);
        foreach (x[i]) x[i] = int'($urandom_range(0, 1000)) - 500;
        run_frame(x, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
